// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer: default width, counter width
// helper and the output-holder state encoding.
package sipo_pkg;

  localparam int WIDTH_DEFAULT = 4;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/sipo_shift_core.sv
// Bit-assembly path: stores accepted bits LSB-first, tracks the bit count and
// flags the edge at which a full word is completed.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sin,
  input  logic                     sin_valid,
  input  logic                     sin_first,
  output logic [WIDTH-1:0]         word,
  output logic                     complete,
  output logic [$clog2(WIDTH)-1:0] cnt
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;

  // A frame-start bit always begins a new word, so it can never complete one.
  assign complete = sin_valid && !sin_first && (cnt == LAST);

  // The completed word includes the bit being accepted on this edge.
  always_comb begin
    word            = sreg;
    word[WIDTH-1]   = sin;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (sin_valid) begin
      if (sin_first) begin
        sreg[0] <= sin;
        cnt     <= CW'(1);
      end else begin
        sreg[cnt] <= sin;
        cnt       <= complete ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words and holds each one
// on pout under a valid/ready handshake, pulsing overrun when a word is dropped.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sin,
  input  logic                     sin_valid,
  input  logic                     sin_first,
  output logic [WIDTH-1:0]         pout,
  output logic                     pout_valid,
  input  logic                     pout_ready,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  // Handshake: a word transfers on any rising edge where pout_valid and
  // pout_ready are both 1; while pout_valid=1 and pout_ready=0, pout is frozen.

  logic [WIDTH-1:0]         word;
  logic                     complete;
  logic [$clog2(WIDTH)-1:0] cnt;

  out_state_e state, state_next;
  logic       load;
  logic       overrun_next;

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sin_first (sin_first),
    .word      (word),
    .complete  (complete),
    .cnt       (cnt)
  );

  assign bit_cnt    = cnt;
  assign pout_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      pout    <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_next;
      overrun <= overrun_next;
      if (load) pout <= word;
    end
  end

  always_comb begin
    state_next   = state;
    load         = 1'b0;
    overrun_next = 1'b0;
    unique case (state)
      EMPTY: begin
        if (complete) begin
          load       = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (pout_ready) begin
          // Consume and refill on the same edge keeps the output gap-free.
          if (complete) load = 1'b1;
          else          state_next = EMPTY;
        end else if (complete) begin
          overrun_next = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

endmodule
